ysyx_24070014_mem_arbiter: RTL and testbench

Shares the core's single memory port between the instruction-fetch requester (IFU) and the load/store requester (LSU). The block grants one requester at a time with a round-robin policy and holds at most one outstanding transaction. It drives a valid/ready request channel toward memory and returns each response to the granted requester. A response timeout lets the core report a bus fault instead of hanging. It sits between the core's fetch/LSU paths and the simulation memory model or bus bridge.

---
 rtl/ysyx_24070014_mem_pkg.sv | 36 +++
 rtl/ysyx_24070014_rr_arb2.sv | 39 +++
 rtl/ysyx_24070014_mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_ysyx_24070014_mem_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24070014_mem_pkg.sv
// Shared definitions for the IFU/LSU memory-port arbiter: FSM encoding,
// requester ids, default timeout and the round-robin pick function.
package ysyx_24070014_mem_pkg;

    // Transaction FSM: one outstanding request at a time.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Requester ids; the last-grant pointer holds one of these.
    localparam logic ID_IFU = 1'b0;
    localparam logic ID_LSU = 1'b1;

    // Cycles a WAIT may last before the block answers with a bus fault.
    localparam int DEFAULT_TIMEOUT = 255;

    // Two-way round-robin pick: a lone requester wins outright, and a tie
    // goes to whoever was not granted last. Returns ID_IFU when neither
    // is requesting; callers qualify the result with their own valid.
    function automatic logic rr_pick(input logic ifu_v, input logic lsu_v,
                                     input logic last_id);
        logic pick;
        if (ifu_v && lsu_v) begin
            pick = (last_id == ID_LSU) ? ID_IFU : ID_LSU;
        end else if (lsu_v) begin
            pick = ID_LSU;
        end else begin
            pick = ID_IFU;
        end
        return pick;
    endfunction

endpackage

// File: rtl/ysyx_24070014_rr_arb2.sv
// Two-input round-robin arbiter: combinational grant plus the registered
// last-grant pointer. Grants only when enabled by the owning FSM.
module ysyx_24070014_rr_arb2
    import ysyx_24070014_mem_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req_ifu,
    input  logic req_lsu,
    output logic gnt_valid,
    output logic gnt_id,
    output logic gnt_ifu,
    output logic gnt_lsu
);

    logic last_q;
    logic last_d;

    // Grant decision and pointer update; the pointer moves on every grant
    // so ties alternate strictly.
    always_comb begin
        gnt_valid = en && (req_ifu || req_lsu);
        gnt_id    = rr_pick(req_ifu, req_lsu, last_q);
        gnt_ifu   = gnt_valid && (gnt_id == ID_IFU);
        gnt_lsu   = gnt_valid && (gnt_id == ID_LSU);
        last_d    = gnt_valid ? gnt_id : last_q;
    end

    // Last-grant pointer; resets to LSU so IFU wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= ID_LSU;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/ysyx_24070014_mem_arbiter.sv
// Shares the single memory port between instruction fetch and load/store.
// One transaction in flight; responses are registered and returned to the
// granted requester as a one-cycle pulse; a stuck WAIT ends in a fault.
module ysyx_24070014_mem_arbiter
    import ysyx_24070014_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,

    output logic                ifu_resp_valid,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic                id_q,    id_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q,   err_d;
    logic                ifu_rv_q, ifu_rv_d;
    logic                lsu_rv_q, lsu_rv_d;

    logic arb_en;
    logic gnt_valid;
    logic gnt_id;
    logic gnt_ifu;
    logic gnt_lsu;

    // Grants are only offered from IDLE; holding off during reset keeps
    // every output low while reset is asserted.
    assign arb_en = (state_q == ST_IDLE) && !reset;

    ysyx_24070014_rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .en        (arb_en),
        .req_ifu   (ifu_req_valid),
        .req_lsu   (lsu_req_valid),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .gnt_ifu   (gnt_ifu),
        .gnt_lsu   (gnt_lsu)
    );

    assign ifu_req_ready  = gnt_ifu;
    assign lsu_req_ready  = gnt_lsu;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign mem_wmask      = wmask_q;
    assign resp_rdata     = rdata_q;
    assign resp_err       = err_q;
    assign ifu_resp_valid = ifu_rv_q;
    assign lsu_resp_valid = lsu_rv_q;

    // Next-state, request latching, timeout counting and response staging.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wmask_d       = wmask_q;
        id_d          = id_q;
        cnt_d         = cnt_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        ifu_rv_d      = 1'b0;
        lsu_rv_d      = 1'b0;
        mem_req_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    id_d    = gnt_id;
                    state_d = ST_ISSUE;
                    if (gnt_id == ID_LSU) begin
                        addr_d  = lsu_addr;
                        wdata_d = lsu_wdata;
                        wmask_d = lsu_wmask;
                    end else begin
                        // Fetches are always reads.
                        addr_d  = ifu_addr;
                        wdata_d = '0;
                        wmask_d = '0;
                    end
                end
            end

            ST_ISSUE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (mem_resp_valid) begin
                    rdata_d = mem_rdata;
                    err_d   = 1'b0;
                    ifu_rv_d = (id_q == ID_IFU);
                    lsu_rv_d = (id_q == ID_LSU);
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LIMIT) begin
                    // Give up: fault the requester, then swallow the late reply.
                    rdata_d = '0;
                    err_d   = 1'b1;
                    ifu_rv_d = (id_q == ID_IFU);
                    lsu_rv_d = (id_q == ID_LSU);
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DRAIN: begin
                if (mem_resp_valid) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            id_q     <= ID_IFU;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            ifu_rv_q <= 1'b0;
            lsu_rv_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
            id_q     <= id_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            ifu_rv_q <= ifu_rv_d;
            lsu_rv_q <= lsu_rv_d;
        end
    end

    // Memory may only answer while a transaction is outstanding.
    assert property (@(posedge clk) disable iff (reset)
        !(mem_resp_valid && ((state_q == ST_IDLE) || (state_q == ST_ISSUE))));

endmodule

// File: tb/tb_ysyx_24070014_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter (TIMEOUT=4).
module tb_ysyx_24070014_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        lsu_req_valid, lsu_req_ready;
    logic [31:0] lsu_addr, lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        ifu_resp_valid, lsu_resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_24070014_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .ifu_resp_valid(ifu_resp_valid), .lsu_resp_valid(lsu_resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 2 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1;
        ifu_req_valid = 0; ifu_addr = 0;
        lsu_req_valid = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wmask = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;

        // Reset state
        tick(); tick(); #1;
        check("rst_ifu_ready", ifu_req_ready, 0);
        check("rst_mem_valid", mem_req_valid, 0);
        check("rst_resp", {ifu_resp_valid, lsu_resp_valid, resp_err}, 0);
        check("rst_rdata", resp_rdata, 0);
        reset = 1'b0;
        tick();

        // Single IFU read with minimum latency
        ifu_req_valid = 1; ifu_addr = 32'h8000_0000; mem_req_ready = 1; #1;
        check("t1_ifu_ready", ifu_req_ready, 1);
        check("t1_lsu_ready", lsu_req_ready, 0);
        tick(); ifu_req_valid = 0; #1;
        check("t1_mem_valid", mem_req_valid, 1);
        check("t1_mem_addr", mem_addr, 32'h8000_0000);
        check("t1_mem_wmask", mem_wmask, 0);
        tick(); mem_resp_valid = 1; mem_rdata = 32'h0000_0413; #1;
        check("t1_no_early_resp", ifu_resp_valid, 0);
        tick(); mem_resp_valid = 0; #1;
        check("t1_ifu_resp", ifu_resp_valid, 1);
        check("t1_lsu_resp", lsu_resp_valid, 0);
        check("t1_rdata", resp_rdata, 32'h0000_0413);
        check("t1_err", resp_err, 0);
        tick(); #1;
        check("t1_pulse_end", ifu_resp_valid, 0);
        $display("txn1 ifu read done");

        // LSU store with 3 stalled ISSUE cycles
        lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wdata = 32'hDEAD_BEEF;
        lsu_wmask = 4'hF; mem_req_ready = 0; #1;
        check("t2_lsu_ready", lsu_req_ready, 1);
        check("t2_ifu_ready", ifu_req_ready, 0);
        tick(); lsu_req_valid = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wmask = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t2_stall_valid", mem_req_valid, 1);
            check("t2_stall_addr", mem_addr, 32'h8000_1000);
            check("t2_stall_wdata", mem_wdata, 32'hDEAD_BEEF);
            check("t2_stall_wmask", mem_wmask, 4'hF);
            tick();
        end
        mem_req_ready = 1; #1;
        check("t2_issue_valid", mem_req_valid, 1);
        tick(); mem_resp_valid = 1; mem_rdata = 0; #1;
        check("t2_wait_no_req", mem_req_valid, 0);
        tick(); mem_resp_valid = 0; #1;
        check("t2_lsu_resp", lsu_resp_valid, 1);
        check("t2_ifu_resp", ifu_resp_valid, 0);
        check("t2_err", resp_err, 0);
        tick(); #1;
        check("t2_pulse_end", lsu_resp_valid, 0);
        $display("txn2 lsu store done");

        // Both valid continuously: grants alternate starting with IFU
        ifu_req_valid = 1; ifu_addr = 32'h0000_1000;
        lsu_req_valid = 1; lsu_addr = 32'h0000_2000; lsu_wdata = 0; lsu_wmask = 0;
        mem_req_ready = 1;
        for (int i = 0; i < 6; i++) begin
            logic exp_ifu;
            exp_ifu = (i % 2 == 0);
            #1;
            check("t3_ifu_ready", ifu_req_ready, exp_ifu);
            check("t3_lsu_ready", lsu_req_ready, !exp_ifu);
            tick(); #1;
            check("t3_issue_ready", {ifu_req_ready, lsu_req_ready}, 0);
            check("t3_mem_addr", mem_addr, exp_ifu ? 32'h0000_1000 : 32'h0000_2000);
            tick(); mem_resp_valid = 1; mem_rdata = 32'h100 + i;
            tick(); mem_resp_valid = 0;
            if (i == 5) begin
                ifu_req_valid = 0; lsu_req_valid = 0;
            end
            #1;
            check("t3_ifu_resp", ifu_resp_valid, exp_ifu);
            check("t3_lsu_resp", lsu_resp_valid, !exp_ifu);
            check("t3_rdata", resp_rdata, 32'h100 + i);
            $display("txn3.%0d grant=%s", i, exp_ifu ? "IFU" : "LSU");
        end
        tick();

        // Timeout: memory never responds; fault on the 5th WAIT cycle
        ifu_req_valid = 1; ifu_addr = 32'h0000_3000; mem_req_ready = 1;
        mem_rdata = 32'hBAD0_BAD0; #1;
        check("t4_ifu_ready", ifu_req_ready, 1);
        tick(); ifu_req_valid = 0;
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t4_no_resp_yet", ifu_resp_valid, 0);
            tick();
        end
        lsu_req_valid = 1; lsu_addr = 32'h0000_5000; lsu_wmask = 0; #1;
        check("t4_timeout_valid", ifu_resp_valid, 1);
        check("t4_timeout_err", resp_err, 1);
        check("t4_timeout_rdata", resp_rdata, 0);
        check("t4_drain_block", lsu_req_ready, 0);
        tick(); #1;
        check("t4_pulse_end", ifu_resp_valid, 0);
        check("t4_drain_block2", lsu_req_ready, 0);
        mem_resp_valid = 1; mem_rdata = 32'h1111_1111;
        tick(); mem_resp_valid = 0; #1;
        check("t4_late_discard", {ifu_resp_valid, lsu_resp_valid}, 0);
        check("t4_late_rdata", resp_rdata, 0);
        check("t4_idle_grant", lsu_req_ready, 1);
        tick(); lsu_req_valid = 0; #1;
        check("t4_lsu_addr", mem_addr, 32'h0000_5000);
        tick(); mem_resp_valid = 1; mem_rdata = 32'h2222_2222;
        tick(); mem_resp_valid = 0; #1;
        check("t4_lsu_resp", lsu_resp_valid, 1);
        check("t4_err_clear", resp_err, 0);
        check("t4_lsu_rdata", resp_rdata, 32'h2222_2222);
        $display("txn4 timeout and recovery done");

        // Reset while in WAIT after an IFU grant
        ifu_req_valid = 1; ifu_addr = 32'h0000_4000; #1;
        check("t5_ifu_ready", ifu_req_ready, 1);
        tick(); ifu_req_valid = 0;
        tick(); #1;
        check("t5_pre_addr", mem_addr, 32'h0000_4000);
        reset = 1; mem_resp_valid = 1; mem_rdata = 32'h3333_3333; #1;
        check("t5_rst_mem_addr", mem_addr, 0);
        check("t5_rst_mem_valid", mem_req_valid, 0);
        check("t5_rst_outs", {ifu_req_ready, lsu_req_ready, ifu_resp_valid,
                              lsu_resp_valid, resp_err}, 0);
        tick(); mem_resp_valid = 0; reset = 0; #1;
        check("t5_no_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
        tick(); #1;
        check("t5_no_resp2", {ifu_resp_valid, lsu_resp_valid}, 0);
        check("t5_rdata", resp_rdata, 0);
        ifu_req_valid = 1; ifu_addr = 32'h0000_6000;
        lsu_req_valid = 1; lsu_addr = 32'h0000_7000; #1;
        check("t5_tie_ifu", ifu_req_ready, 1);
        check("t5_tie_lsu", lsu_req_ready, 0);
        $display("txn5 reset in WAIT done");

        // New LSU request in the cycle the IFU response pulses
        tick(); ifu_req_valid = 0; lsu_req_valid = 0;
        tick(); mem_resp_valid = 1; mem_rdata = 32'h0000_0044;
        tick(); mem_resp_valid = 0;
        lsu_req_valid = 1; lsu_addr = 32'h0000_8000; lsu_wdata = 32'h1234_5678;
        lsu_wmask = 4'h3; #1;
        check("t6_ifu_resp", ifu_resp_valid, 1);
        check("t6_rdata", resp_rdata, 32'h0000_0044);
        check("t6_lsu_ready", lsu_req_ready, 1);
        tick(); lsu_req_valid = 0; #1;
        check("t6_mem_wmask", mem_wmask, 4'h3);
        check("t6_mem_wdata", mem_wdata, 32'h1234_5678);
        check("t6_mem_addr", mem_addr, 32'h0000_8000);
        tick(); mem_resp_valid = 1; mem_rdata = 0;
        tick(); mem_resp_valid = 0; #1;
        check("t6_lsu_resp", lsu_resp_valid, 1);
        $display("txn6 back-to-back grant done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
